// File: rtl/arm_decode_family.sv
// Registered ARMv4 instruction-family decoder: one multi-hot bit per family, 1-cycle latency.
// Optional DECODE_PRIORITY_EN adds fam_hit / fam_id (highest-priority family index).
module arm_decode_family (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_valid,
  input  logic [31:0] ir,
  output logic [15:0] f,
`ifdef DECODE_PRIORITY_EN
  output logic        fam_hit,
  output logic [3:0]  fam_id,
`endif
  output logic        f_valid
);

  logic [15:0] dec;
  logic [15:0] f_d, f_q;
  logic        f_valid_d, f_valid_q;

  // Condition field ir[31:28] never enters any equation.
  always_comb begin
    dec     = '0;
    dec[0]  = (ir[27:25] == 3'b001);
    dec[1]  = (ir[27:25] == 3'b000) && !ir[4];
    dec[2]  = (ir[27:25] == 3'b000) && !ir[7] && ir[4];
    dec[3]  = (ir[27:22] == 6'b000000) && (ir[7:4] == 4'b1001);
    dec[4]  = (ir[27:23] == 5'b00001) && (ir[7:4] == 4'b1001);
    dec[5]  = (ir[27:23] == 5'b00010) && (ir[21:20] == 2'b00);
    dec[6]  = (ir[27:23] == 5'b00110) && (ir[21:20] == 2'b10);
    dec[7]  = (ir[27:23] == 5'b00010) && (ir[21:20] == 2'b10) && !ir[4];
    dec[8]  = (ir[27:25] == 3'b010);
    dec[9]  = (ir[27:25] == 3'b011) && !ir[4];
    dec[10] = (ir[27:25] == 3'b000) && ir[22] && ir[7] && ir[4];
    dec[11] = (ir[27:25] == 3'b000) && !ir[22] && ir[7] && ir[4];
    dec[12] = (ir[27:23] == 5'b00010) && (ir[21:20] == 2'b00) && (ir[7:4] == 4'b1001);
    dec[13] = (ir[27:25] == 3'b100);
    dec[14] = (ir[27:25] == 3'b101);
    dec[15] = (ir[27:25] == 3'b011) && ir[4];
  end

  // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
  always_comb begin
    f_d       = f_q;
    f_valid_d = 1'b0;
    if (ir_valid) begin
      f_d       = dec;
      f_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q       <= '0;
      f_valid_q <= 1'b0;
    end else begin
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
    end
  end

  assign f       = f_q;
  assign f_valid = f_valid_q;

`ifdef DECODE_PRIORITY_EN
  localparam logic [3:0] PRIO [16] = '{4'd12, 4'd3, 4'd4, 4'd10, 4'd11, 4'd5, 4'd7, 4'd6,
                                       4'd2, 4'd1, 4'd0, 4'd8, 4'd9, 4'd15, 4'd13, 4'd14};
  logic       hit_d, hit_q;
  logic [3:0] id_d, id_q, id_dec;

  // Walk from lowest to highest priority so the highest set family is written last.
  always_comb begin
    id_dec = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (dec[PRIO[i]]) id_dec = PRIO[i];
    end
  end

  always_comb begin
    hit_d = hit_q;
    id_d  = id_q;
    if (ir_valid) begin
      hit_d = |dec;
      id_d  = id_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      id_q  <= 4'd0;
    end else begin
      hit_q <= hit_d;
      id_q  <= id_d;
    end
  end

  assign fam_hit = hit_q;
  assign fam_id  = id_q;
`endif

endmodule

// File: tb/tb_arm_decode_family.sv
// Self-checking bench for arm_decode_family: mask/match table model, per-cycle compare, directed literals.
module tb_arm_decode_family;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir_valid = 1'b0;
  logic [31:0] ir = '0;
  logic [15:0] f;
  logic        f_valid;
`ifdef DECODE_PRIORITY_EN
  logic        fam_hit;
  logic [3:0]  fam_id;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arm_decode_family dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir_valid (ir_valid),
    .ir       (ir),
    .f        (f),
`ifdef DECODE_PRIORITY_EN
    .fam_hit  (fam_hit),
    .fam_id   (fam_id),
`endif
    .f_valid  (f_valid)
  );

  // Each family is a (mask, match) pair over the instruction word.
  logic [31:0] fam_mask  [16];
  logic [31:0] fam_match [16];
  int          prio      [16] = '{12, 3, 4, 10, 11, 5, 7, 6, 2, 1, 0, 8, 9, 15, 13, 14};

  initial begin
    fam_mask[0]  = 32'h0E00_0000; fam_match[0]  = 32'h0200_0000;
    fam_mask[1]  = 32'h0E00_0010; fam_match[1]  = 32'h0000_0000;
    fam_mask[2]  = 32'h0E00_0090; fam_match[2]  = 32'h0000_0010;
    fam_mask[3]  = 32'h0FC0_00F0; fam_match[3]  = 32'h0000_0090;
    fam_mask[4]  = 32'h0F80_00F0; fam_match[4]  = 32'h0080_0090;
    fam_mask[5]  = 32'h0FB0_0000; fam_match[5]  = 32'h0100_0000;
    fam_mask[6]  = 32'h0FB0_0000; fam_match[6]  = 32'h0320_0000;
    fam_mask[7]  = 32'h0FB0_0010; fam_match[7]  = 32'h0120_0000;
    fam_mask[8]  = 32'h0E00_0000; fam_match[8]  = 32'h0400_0000;
    fam_mask[9]  = 32'h0E00_0010; fam_match[9]  = 32'h0600_0000;
    fam_mask[10] = 32'h0E40_0090; fam_match[10] = 32'h0040_0090;
    fam_mask[11] = 32'h0E40_0090; fam_match[11] = 32'h0000_0090;
    fam_mask[12] = 32'h0FB0_00F0; fam_match[12] = 32'h0100_0090;
    fam_mask[13] = 32'h0E00_0000; fam_match[13] = 32'h0800_0000;
    fam_mask[14] = 32'h0E00_0000; fam_match[14] = 32'h0A00_0000;
    fam_mask[15] = 32'h0E00_0010; fam_match[15] = 32'h0600_0010;
  end

  function automatic logic [15:0] model_f(input logic [31:0] w);
    logic [15:0] r = '0;
    for (int k = 0; k < 16; k++) r[k] = ((w & fam_mask[k]) == fam_match[k]);
    return r;
  endfunction

  function automatic logic [3:0] model_id(input logic [15:0] v);
    for (int k = 0; k < 16; k++) if (v[prio[k]]) return 4'(prio[k]);
    return 4'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs, advanced from the same sampled inputs the DUT sees.
  logic [15:0] exp_f;
  logic        exp_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_f <= '0;
      exp_v <= 1'b0;
    end else begin
      exp_v <= ir_valid;
      if (ir_valid) exp_f <= model_f(ir);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_f", 32'(f), 32'(exp_f));
      check("cyc_f_valid", 32'(f_valid), 32'(exp_v));
`ifdef DECODE_PRIORITY_EN
      check("cyc_fam_hit", 32'(fam_hit), 32'(|exp_f));
      check("cyc_fam_id", 32'(fam_id), 32'(model_id(exp_f)));
`endif
    end
  end

  task automatic drive(input logic v, input logic [31:0] w);
    ir_valid = v;
    ir       = w;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input logic [15:0] ef, input logic ev);
    check({name, "_f"}, 32'(f), 32'(ef));
    check({name, "_valid"}, 32'(f_valid), 32'(ev));
  endtask

  initial begin
    logic [31:0] w;
    #12;
    check("reset_f", 32'(f), 32'h0);
    check("reset_valid", 32'(f_valid), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    drive(1, 32'h0000_0000); expect_lit("dp_imm_shift", 16'h0002, 1);
    drive(1, 32'hE3A0_0001); expect_lit("dp_imm", 16'h0001, 1);
    drive(1, 32'hEAFF_FFFE); expect_lit("branch", 16'h4000, 1);
    drive(1, 32'hE7F0_00F0); expect_lit("undef", 16'h8000, 1);
    drive(1, 32'hEF00_0000); expect_lit("swi", 16'h0000, 1);
    drive(1, 32'h0000_0090); expect_lit("mul_hw", 16'h0808, 1);
    drive(1, 32'h0100_0090); expect_lit("swp", 16'h1820, 1);
`ifdef DECODE_PRIORITY_EN
    check("swp_id", 32'(fam_id), 32'd12);
    check("swp_hit", 32'(fam_hit), 32'd1);
`endif
    drive(1, 32'h0320_F000); expect_lit("msr_imm", 16'h0041, 1);
`ifdef DECODE_PRIORITY_EN
    check("msr_imm_id", 32'(fam_id), 32'd6);
`endif

    for (int c = 0; c < 16; c++) begin
      drive(1, {4'(c), 28'h3A0_0001});
      expect_lit($sformatf("cond_%0d", c), 16'h0001, 1);
    end

    drive(1, 32'hE590_0000); expect_lit("ldr", 16'h0100, 1);
    drive(0, 32'hEAFF_FFFE); expect_lit("hold", 16'h0100, 0);
    drive(0, 32'hEAFF_FFFE); expect_lit("hold2", 16'h0100, 0);
    drive(1, 32'hEAFF_FFFE); expect_lit("b2b_0", 16'h4000, 1);
    drive(1, 32'h0000_0000); expect_lit("b2b_1", 16'h0002, 1);
    drive(1, 32'hE590_0000); expect_lit("b2b_2", 16'h0100, 1);

    // Asynchronous reset in mid-cycle with f nonzero.
    ir_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_f", 32'(f), 32'h0);
    check("async_rst_valid", 32'(f_valid), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10000; i++) begin
      w = $urandom;
      if (i % 2 == 1) w[27:24] = 4'($urandom_range(0, 3));
      drive(($urandom_range(0, 7) != 0), w);
    end

    ir_valid = 1'b0;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
